mc_ctrl_fsm: RTL and testbench

- Multicycle MIPS main controller. It sits directly upstream of the ALU decoder/ALU pair and drives aluop, the ALU source muxes, PC enable and the register-file/memory strobes, one instruction step per state.
- Memory accesses stall on a ready handshake.
- Outputs are Moore, decoded from the state register, except signals gated by mem_ready or zero.

---
 rtl/mc_ctrl_fsm.sv | 197 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm - multicycle MIPS main controller.
//
// Steps one instruction through FETCH/DECODE/execute/writeback and drives
// the ALU control, the datapath mux selects, the PC enable and the
// register-file and memory strobes. Memory accesses in FETCH, MEMRD and
// MEMWR wait for a mem_ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset (forces FETCH)
//   op         opcode field of the instruction register
//   zero       ALU zero flag (used by BEQ)
//   mem_ready  memory completes the current request this cycle
//   mem_req, memwrite, iord, irwrite           memory/IR controls
//   regdst, memtoreg, regwrite                 register-file controls
//   alusrca, alusrcb, aluop                    ALU controls
//   pcsrc, pcen                                PC controls
//   illegal_op unsupported opcode seen in DECODE (one-cycle pulse)
//   state_o    current state, exported for verification
//
// state   | meaning
// --------+---------------------------------------------
// FETCH   | read instruction at PC, PC <= PC + 4
// DECODE  | register read, branch target precompute
// MEMADR  | effective address = A + signimm
// MEMRD   | data read at ALUOut
// MEMWB   | write MDR to rt
// MEMWR   | data write at ALUOut
// RTYPEEX | A funct B
// RTYPEWB | write ALUOut to rd
// BEQEX   | A - B, load PC from ALUOut if equal
// ADDIEX  | A + signimm
// ADDIWB  | write ALUOut to rt
// JEX     | PC <= jump target

module mc_ctrl_fsm #(
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [5:0]     op,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           memwrite,
    output logic           iord,
    output logic           irwrite,
    output logic           regdst,
    output logic           memtoreg,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     aluop,
    output logic [1:0]     pcsrc,
    output logic           pcen,
    output logic           illegal_op,
    output logic [STW-1:0] state_o
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    state_t state, state_nxt;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = FETCH;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;

        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alusrcb   = 2'b01;
                irwrite   = mem_ready;
                pcwrite   = mem_ready;
                state_nxt = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = RTYPEEX;
                    OP_BEQ:       state_nxt = BEQEX;
                    OP_ADDI:      state_nxt = ADDIEX;
                    OP_J:         state_nxt = JEX;
                    default: begin
                        state_nxt  = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                // IR is stable, so the opcode is simply looked at again.
                if (op == OP_LW) begin
                    state_nxt = MEMRD;
                end else if (op == OP_SW) begin
                    state_nxt = MEMWR;
                end else begin
                    state_nxt = FETCH;
                end
            end
            MEMRD: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                state_nxt = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                // Strobe held steady until the single write is accepted.
                mem_req   = 1'b1;
                iord      = 1'b1;
                memwrite  = 1'b1;
                state_nxt = mem_ready ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca   = 1'b1;
                aluop     = 2'b10;
                state_nxt = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                state_nxt = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign pcen    = pcwrite | (branch & zero);
    assign state_o = STW'(state);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal_op;
    } exp_t;

    // Phase numbers as published for state_o.
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3,
                   P_MEMWB = 4, P_MEMWR = 5, P_RTEX = 6, P_RTWB = 7,
                   P_BEQ = 8, P_ADDIEX = 9, P_ADDIWB = 10, P_JEX = 11;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_R = 6'b000000, OP_BEQ = 6'b000100,
                           OP_ADDI = 6'b001000, OP_J = 6'b000010;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, pcen, illegal_op;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_idx = 0;
    exp_t exp_q[$];
    exp_t act;

    mc_ctrl_fsm #(.STW(4)) dut (
        .clk(clk), .resetn(resetn), .op(op), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .iord(iord), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign act = {state_o, mem_req, memwrite, iord, irwrite, regdst,
                  memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc,
                  pcen, illegal_op};

    // Output expected in a given step of the instruction sequence.
    function automatic exp_t expect_out(input int ph, input logic mr,
                                        input logic z, input logic ill);
        exp_t e;
        e = '0;
        e.st = 4'(ph);
        case (ph)
            P_FETCH:  begin e.mem_req = 1; e.alusrcb = 2'b01;
                            e.irwrite = mr; e.pcen = mr; end
            P_DECODE: begin e.alusrcb = 2'b11; e.illegal_op = ill; end
            P_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            P_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
            P_MEMWB:  begin e.memtoreg = 1; e.regwrite = 1; end
            P_MEMWR:  begin e.mem_req = 1; e.iord = 1; e.memwrite = 1; end
            P_RTEX:   begin e.alusrca = 1; e.aluop = 2'b10; end
            P_RTWB:   begin e.regdst = 1; e.regwrite = 1; end
            P_BEQ:    begin e.alusrca = 1; e.aluop = 2'b01;
                            e.pcsrc = 2'b01; e.pcen = z; end
            P_ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            P_ADDIWB: begin e.regwrite = 1; end
            P_JEX:    begin e.pcsrc = 2'b10; e.pcen = 1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL trace cycle %0d: got %h expected %h (state got %0d want %0d)",
                         cyc_idx, act, e, act.st, e.st);
            end
            cyc_idx++;
        end
    end

    // One clock cycle: drive inputs, record what the outputs must be.
    task automatic step(input int ph, input logic mr, input logic z,
                        input logic ill);
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(expect_out(ph, mr, z, ill));
        @(posedge clk);
        #1;
    endtask

    // One instruction as a sequence of phases with the given stalls.
    task automatic run_instr(input logic [5:0] o, input logic zb,
                             input int fs, input int ms);
        logic legal;
        op = o;
        for (int i = 0; i < fs; i++) step(P_FETCH, 1'b0, rbit(), 1'b0);
        step(P_FETCH, 1'b1, rbit(), 1'b0);
        legal = (o == OP_LW) || (o == OP_SW) || (o == OP_R) ||
                (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
        step(P_DECODE, rbit(), rbit(), !legal);
        if (o == OP_LW) begin
            step(P_MEMADR, rbit(), rbit(), 1'b0);
            for (int i = 0; i < ms; i++) step(P_MEMRD, 1'b0, rbit(), 1'b0);
            step(P_MEMRD, 1'b1, rbit(), 1'b0);
            step(P_MEMWB, rbit(), rbit(), 1'b0);
        end else if (o == OP_SW) begin
            step(P_MEMADR, rbit(), rbit(), 1'b0);
            for (int i = 0; i < ms; i++) step(P_MEMWR, 1'b0, rbit(), 1'b0);
            step(P_MEMWR, 1'b1, rbit(), 1'b0);
        end else if (o == OP_R) begin
            step(P_RTEX, rbit(), rbit(), 1'b0);
            step(P_RTWB, rbit(), rbit(), 1'b0);
        end else if (o == OP_BEQ) begin
            step(P_BEQ, rbit(), zb, 1'b0);
        end else if (o == OP_ADDI) begin
            step(P_ADDIEX, rbit(), rbit(), 1'b0);
            step(P_ADDIWB, rbit(), rbit(), 1'b0);
        end else if (o == OP_J) begin
            step(P_JEX, rbit(), rbit(), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops[7];
        logic [5:0] ro;
        ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_BEQ;
        ops[4] = OP_ADDI; ops[5] = OP_J; ops[6] = 6'b111111;

        // Reset state, both mem_ready levels.
        #2;
        chk("reset_outputs_mr0", int'(act), int'(expect_out(P_FETCH, 1'b0, 1'b0, 1'b0)));
        mem_ready = 1'b1;
        #1;
        chk("reset_outputs_mr1", int'(act), int'(expect_out(P_FETCH, 1'b1, 1'b0, 1'b0)));
        mem_ready = 1'b0;
        #5;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed sequences.
        run_instr(OP_R,    1'b0, 0, 0);
        run_instr(OP_LW,   1'b0, 2, 3);
        run_instr(OP_SW,   1'b0, 0, 1);
        run_instr(OP_BEQ,  1'b1, 0, 0);
        run_instr(OP_BEQ,  1'b0, 0, 0);
        run_instr(OP_J,    1'b0, 0, 0);
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(OP_ADDI, 1'b0, 1, 0);

        // Asynchronous reset while stalled in MEMRD.
        op = OP_LW;
        step(P_FETCH, 1'b1, 1'b0, 1'b0);
        step(P_DECODE, 1'b0, 1'b0, 1'b0);
        step(P_MEMADR, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        exp_q.push_back(expect_out(P_MEMRD, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_reset_state", int'(state_o), 0);
        chk("async_reset_mem_req", int'(mem_req), 1);
        chk("async_reset_iord", int'(iord), 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_instr(OP_R, 1'b0, 1, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) ro = 6'($urandom);
            else ro = ops[$urandom_range(0, 5)];
            run_instr(ro, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
